// File: rtl/yarvi_wb_arb.sv
// Writeback arbiter for the yarvi register file: ALU-priority grant with ld/md round-robin,
// a registered write port, and a scoreboard of pending long-latency destinations.
module yarvi_wb_arb (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_d,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_d,
  output logic        ld_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [63:0] md_d,
  output logic        md_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        iss_long,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        stall,
  output logic        we,
  output logic [4:0]  addr,
  output logic [63:0] d,
  output logic [31:0] busy
);

  // ptr_q = 0 favours the load unit, 1 favours mul/div.
  logic        ptr_q, ptr_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [63:0] d_q, d_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_vec, clr_vec;
  logic        ld_fire, md_fire;

  // Readies depend only on the ALU, the pointer and the other source's valid.
  assign ld_ready = reset_n & ~alu_valid & (~ptr_q | ~md_valid);
  assign md_ready = reset_n & ~alu_valid & ( ptr_q | ~ld_valid);
  assign ld_fire  = ld_valid & ld_ready;
  assign md_fire  = md_valid & md_ready;

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    d_d    = d_q;
    if (alu_valid) begin
      we_d   = (alu_rd != 5'd0);
      addr_d = alu_rd;
      d_d    = alu_d;
    end else if (ld_fire) begin
      we_d   = (ld_rd != 5'd0);
      addr_d = ld_rd;
      d_d    = ld_d;
      ptr_d  = 1'b1;
    end else if (md_fire) begin
      we_d   = (md_rd != 5'd0);
      addr_d = md_rd;
      d_d    = md_d;
      ptr_d  = 1'b0;
    end
  end

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (iss_valid && iss_long)
      set_vec = 32'd1 << iss_rd;
    if (ld_fire)
      clr_vec = 32'd1 << ld_rd;
    else if (md_fire)
      clr_vec = 32'd1 << md_rd;
  end

  // Set beats clear on the same register; x0 never becomes busy.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_d[gi] = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= 5'd0;
      d_q    <= 64'd0;
      busy_q <= 32'd0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      d_q    <= d_d;
      busy_q <= busy_d;
    end
  end

  assign stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
  assign we    = we_q;
  assign addr  = addr_q;
  assign d     = d_q;
  assign busy  = busy_q;

endmodule

// File: doc/yarvi_wb_arb.md
YARVI_WB_ARB -- requirements
Module: yarvi_wb_arb

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clock, reset_n.
REQ-002 SHALL have port: clock  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: alu_valid in 1, alu_rd in 5, alu_d in 64: ALU writeback; never stallable, no ready.
REQ-005 SHALL have ports: ld_valid in 1, ld_rd in 5, ld_d in 64, ld_ready out 1: load-unit writeback, valid/ready.
REQ-006 SHALL have ports: md_valid in 1, md_rd in 5, md_d in 64, md_ready out 1: mul/div/CSR writeback, valid/ready.
REQ-007 SHALL have ports: iss_valid in 1, iss_rd in 5, iss_long in 1: issue of an instruction; iss_long marks a load/md destination.
REQ-008 SHALL have ports: chk_rs1 in 5, chk_rs2 in 5, chk_rd in 5: register fields of the instruction entering the register-file stage.
REQ-009 SHALL have output: stall out 1: hazard against a pending long-latency write.
REQ-010 SHALL have outputs: we out 1, addr out 5, d out 64: registered register-file write port.
REQ-011 SHALL have output: busy out 32: scoreboard, bit n = xn pending.

Function
REQ-012 SHALL grant at most one writeback per cycle; ALU has absolute priority.
REQ-013 SHALL drive ld_ready = md_ready = 0 combinationally in any cycle with alu_valid=1.
REQ-014 SHALL, without alu_valid, with only one of ld_valid/md_valid set, assert that source's ready.
REQ-015 SHALL, without alu_valid, with both ld_valid and md_valid set, grant via a 1-bit round-robin pointer.
REQ-016 SHALL, after a granted load transfer, set the pointer to favour md; after a granted md transfer, favour ld.
REQ-017 SHALL leave the pointer unchanged when the ALU wins.
REQ-018 SHALL keep ready independent of its own valid: ready = no alu_valid AND (pointer favours source OR other valid low).
REQ-019 SHALL register the winner: next cycle we=1, addr=rd, d=data, so the write-port latency is exactly 1 cycle.
REQ-020 SHALL drive we=0 for any cycle following a grant-less cycle, and SHALL hold addr/d at their previous values then.
REQ-021 SHALL accept and consume (ready=1) a granted write to x0, but SHALL emit we=0 for it.
REQ-022 SHALL set busy[iss_rd] at posedge when iss_valid & iss_long & iss_rd!=0.
REQ-023 SHALL clear busy[rd] at the posedge where a load/md transfer (valid&ready) for rd completes.
REQ-024 SHALL let set win when set and clear hit the same register in one cycle.
REQ-025 SHALL never set or clear busy from ALU writebacks; busy[0] SHALL be constant 0.
REQ-026 SHALL compute stall combinationally = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], using current-cycle busy; no bypass of same-cycle clears.
REQ-027 SHALL leave clear-on-not-busy a no-op; no error signalled.

Reset
REQ-028 SHALL, while reset_n=0 at posedge, force: busy=0, we=0, addr=0, d=0, pointer favours ld.
REQ-029 SHALL hold ld_ready=md_ready=0 combinationally while reset_n=0; transfers offered then are not consumed.
REQ-030 SHALL discard, on reset mid-operation, any grant made in the reset cycle; no write appears after reset release.

Verification
REQ-031 SHALL cover: alu_valid=1 rd=5 d=0x11 with ld_valid=1 rd=6 -> ld_ready=0; next cycle we=1 addr=5 d=0x11; load written the cycle after.
REQ-032 SHALL cover: ld and md both valid for 4 cycles, no ALU -> grants alternate ld,md,ld,md; we asserted 4 consecutive cycles.
REQ-033 SHALL cover: iss_valid iss_long iss_rd=7, then chk_rs1=7 -> stall=1 until the load to x7 completes; stall=0 the cycle after.
REQ-034 SHALL cover: same-cycle iss set rd=9 and md completion rd=9 -> busy[9]=1 afterward.
REQ-035 SHALL cover: ld_valid rd=0 d=0xFF -> ld_ready=1, next cycle we=0, busy unchanged.
REQ-036 SHALL cover: reset_n=0 with all valids high -> readies 0; after release busy=0, we=0, first contention grants ld.
